// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: divider state encoding, default width
// and the 8-bit carry-lookahead slice used by the adder chains.
package alu_pkg;

   localparam logic [1:0] DIV_IDLE = 2'b00;
   localparam logic [1:0] DIV_RUN  = 2'b01;
   localparam logic [1:0] DIV_DONE = 2'b10;

   localparam int DIV_WIDTH = 32;

   // Returns {carry_out, sum[7:0]}.
   function automatic logic [8:0] cla8(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic       cin
   );
      logic [7:0] g;
      logic [7:0] p;
      logic [8:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      for (int i = 0; i < 8; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return {c[8], p ^ c[7:0]};
   endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, restoring when the trial goes negative.
module div_sub_step
   import alu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   rem_shifted,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   next_rem,
   output logic             q_bit
);

   localparam int NS = (WIDTH + 8) / 8;
   localparam int NB = NS * 8;

   logic [NB-1:0] op_a;
   logic [NB-1:0] op_b;
   logic [NB-1:0] sum;
   logic [NS:0]   carry;
   logic [WIDTH:0] diff;
   logic          unused_bits;

   // Inverted zero-extended divisor; upper pad bits become ones.
   assign op_a     = NB'(rem_shifted);
   assign op_b     = ~NB'({1'b0, divisor});
   assign carry[0] = 1'b1;

   for (genvar s = 0; s < NS; s++) begin : g_slice
      assign {carry[s+1], sum[s*8 +: 8]} =
         cla8(op_a[s*8 +: 8], op_b[s*8 +: 8], carry[s]);
   end

   assign diff        = sum[WIDTH:0];
   assign q_bit       = ~diff[WIDTH];
   assign next_rem    = q_bit ? diff : rem_shifted;
   assign unused_bits = ^{sum[NB-1:WIDTH+1], carry[NS]};

endmodule

// File: rtl/div_restoring_seq.sv
// Multicycle signed radix-2 restoring divider; one step per clock,
// single-cycle completion strobe and sticky divide-by-zero flag.
module div_restoring_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int NS    = (WIDTH + 8) / 8;
   localparam int NB    = NS * 8;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] quo;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] dvsr;
   logic             sign_q;
   logic             div0;

   logic [WIDTH:0]   rem_shifted;
   logic [WIDTH:0]   next_rem;
   logic             q_bit;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH-1:0] signed_quo;

   logic [NB-1:0]    neg_a;
   logic [NB-1:0]    neg_sum;
   logic [NS:0]      neg_c;
   logic             unused_bits;

   assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

   assign rem_shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};

   div_sub_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_shifted (rem_shifted),
      .divisor     (dvsr),
      .next_rem    (next_rem),
      .q_bit       (q_bit)
   );

   // Sign fixup: ~quo + 1 through the same lookahead slices.
   assign neg_a    = ~NB'(quo);
   assign neg_c[0] = 1'b1;

   for (genvar s = 0; s < NS; s++) begin : g_neg
      assign {neg_c[s+1], neg_sum[s*8 +: 8]} =
         cla8(neg_a[s*8 +: 8], 8'h00, neg_c[s]);
   end

   assign signed_quo  = sign_q ? neg_sum[WIDTH-1:0] : quo;
   assign unused_bits = ^{neg_sum[NB-1:WIDTH], neg_c[NS], rem[WIDTH]};

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= DIV_IDLE;
         cnt            <= '0;
         quo            <= '0;
         rem            <= '0;
         dvsr           <= '0;
         sign_q         <= 1'b0;
         div0           <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else if (ctrl_DIV) begin
         quo            <= abs_a;
         dvsr           <= abs_b;
         sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         rem            <= '0;
         cnt            <= '0;
         div0           <= (data_operandB == '0);
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         state          <= (data_operandB == '0) ? DIV_DONE : DIV_RUN;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            DIV_RUN: begin
               rem <= next_rem;
               quo <= {quo[WIDTH-2:0], q_bit};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= DIV_DONE;
               end
            end
            DIV_DONE: begin
               data_result    <= div0 ? '0 : signed_quo;
               data_exception <= div0;
               data_resultRDY <= 1'b1;
               state          <= DIV_IDLE;
            end
            default: begin
               state <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_restoring_seq.sv
// Randomized and directed bench for the sequential signed divider,
// compared against a plain-arithmetic quotient model.
module tb_div_restoring_seq;

   localparam int W = 32;

   logic         clock;
   logic         reset;
   logic         ctrl_DIV;
   logic [W-1:0] data_operandA;
   logic [W-1:0] data_operandB;
   logic [W-1:0] data_result;
   logic         data_exception;
   logic         data_resultRDY;

   int checks;
   int errors;

   div_restoring_seq #(
      .WIDTH (W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Returns {exception, quotient}; C-style truncation toward zero.
   function automatic logic [W:0] ref_div(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint q;
      if (b == '0) return {1'b1, {W{1'b0}}};
      q = longint'($signed(a)) / longint'($signed(b));
      return {1'b0, q[W-1:0]};
   endfunction

   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clock);
      ctrl_DIV      = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic wait_rdy(output int n);
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] exp;
      int         n;
      exp = ref_div(a, b);
      start(a, b);
      check("exc_clear", W'(data_exception), W'(0));
      wait_rdy(n);
      check("latency", W'(n), (b == '0) ? W'(1) : W'(W + 1));
      check("result", data_result, exp[W-1:0]);
      check("exception", W'(data_exception), W'(exp[W]));
      @(posedge clock);
      #1;
      check("rdy_pulse", W'(data_resultRDY), W'(0));
      check("hold", data_result, exp[W-1:0]);
   endtask

   initial begin
      int n;
      int strobes;
      logic [W-1:0] a;
      logic [W-1:0] b;
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_result", data_result, '0);
      check("rst_exc", W'(data_exception), W'(0));
      check("rst_rdy", W'(data_resultRDY), W'(0));
      @(negedge clock);
      reset = 1'b0;

      run_op(32'd100, 32'd7);
      run_op(32'hFFFFFF9C, 32'd7);
      run_op(32'hFFFFFF9C, 32'hFFFFFFF9);
      run_op(32'd5, 32'd0);
      run_op(32'h80000000, 32'hFFFFFFFF);
      run_op(32'hFFFFFFFF, 32'h80000000);
      run_op(32'h80000000, 32'd1);
      run_op(32'h7FFFFFFF, 32'h7FFFFFFF);
      run_op(32'd0, 32'hFFFFFFFF);

      // Restart at N+10 aborts the first operation.
      start(32'd1000, 32'd10);
      strobes = 0;
      repeat (9) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) strobes++;
      end
      check("restart_early", W'(strobes), W'(0));
      start(32'd9, 32'd3);
      wait_rdy(n);
      check("restart_lat", W'(n), W'(W + 1));
      check("restart_res", data_result, 32'd3);

      // Reset at N+20 kills the operation and clears outputs.
      start(32'd50, 32'd5);
      repeat (19) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("midrst_result", data_result, '0);
      check("midrst_rdy", W'(data_resultRDY), W'(0));
      @(negedge clock);
      reset   = 1'b0;
      strobes = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) strobes++;
      end
      check("midrst_nostrobe", W'(strobes), W'(0));
      run_op(32'd50, 32'd5);

      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 3))
            0: b = '0;
            1: b = W'($urandom_range(1, 300));
            2: b = -W'($urandom_range(1, 300));
            default: ;
         endcase
         run_op(a, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
